// File: rtl/cluster_clock_gating_pkg.sv
// Shared helpers for the cluster clock gate.
package cluster_cg_pkg;

   // Width of the idle-hold counter: enough bits for 0..delay, never below one bit.
   function automatic int cg_cnt_width(input int delay);
      int w;
      w = $clog2(delay + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cluster_clock_gating_latch.sv
// Resettable enable latch, transparent while clk_i is low.
// Kept on its own so synthesis can swap in a library ICG or latch cell.
module cg_enable_latch (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic en_lat_o
);

   logic r_en_lat;

   always_latch begin
      if (!rst_ni)
         r_en_lat <= 1'b0;
      else if (!clk_i)
         r_en_lat <= en_i;
   end

   assign en_lat_o = r_en_lat;

endmodule

// File: rtl/cluster_clock_gating.sv
// Cluster clock gate: latch-based ICG with test override and optional idle-hold window.
// Define CLUSTER_CLOCK_GATING_FPGA_BYPASS_EN to pass clk_i straight through (no latch).
module cluster_clock_gating
   import cluster_cg_pkg::*;
#(
   parameter int IDLE_DELAY = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o,
   output logic clk_en_o
);

   localparam int CW = cg_cnt_width(IDLE_DELAY);

   logic w_hold;
   logic w_en_req;

   generate
      if (IDLE_DELAY == 0) begin : g_no_hold
         assign w_hold = 1'b0;
      end else begin : g_hold
         logic [CW-1:0] r_cnt;

         // Runs on the ungated clock so the hold window keeps counting down while gated.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
               r_cnt <= '0;
            else if (en_i)
               r_cnt <= CW'(IDLE_DELAY);
            else if (r_cnt != '0)
               r_cnt <= r_cnt - CW'(1);
         end

         assign w_hold = (r_cnt != '0);
      end
   endgenerate

   assign w_en_req = en_i | test_en_i | w_hold;

`ifdef CLUSTER_CLOCK_GATING_FPGA_BYPASS_EN
   logic w_unused;
   assign w_unused = w_en_req;
   assign clk_o    = clk_i;
   assign clk_en_o = 1'b1;
`else
   logic w_en_lat;

   cg_enable_latch u_en_latch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (w_en_req),
      .en_lat_o (w_en_lat)
   );

   assign clk_o    = clk_i & w_en_lat;
   assign clk_en_o = w_en_lat;
`endif

endmodule

// File: tb/tb_cluster_clock_gating.sv
// Directed bench for cluster_clock_gating: a pure ICG instance and an IDLE_DELAY=3 instance.
module tb_cluster_clock_gating;

   logic clk_i     = 1'b0;
   logic rst_ni    = 1'b0;
   logic en_i      = 1'b0;
   logic test_en_i = 1'b0;
   logic clk_o0, clk_en_o0, clk_o3, clk_en_o3;

   int n_pass  = 0;
   int n_total = 0;
   int pc0 = 0, pc3 = 0, short_pulses = 0;
   int b0, b3, exp0, exp3, m_cnt;
   time t0 = 0, t3 = 0;

   always #5 clk_i = ~clk_i;

   cluster_clock_gating #(.IDLE_DELAY(0)) u_dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .test_en_i(test_en_i),
      .clk_o(clk_o0), .clk_en_o(clk_en_o0)
   );

   cluster_clock_gating #(.IDLE_DELAY(3)) u_dut3 (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .test_en_i(test_en_i),
      .clk_o(clk_o3), .clk_en_o(clk_en_o3)
   );

   // Pulse counting and width checking; pulses cut short by reset are expected.
   always @(posedge clk_o0) begin pc0++; t0 = $time; end
   always @(posedge clk_o3) begin pc3++; t3 = $time; end
   always @(negedge clk_o0) if (rst_ni && ($time - t0) != 5) short_pulses++;
   always @(negedge clk_o3) if (rst_ni && ($time - t3) != 5) short_pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic low();
      @(negedge clk_i); #1;
   endtask

   task automatic high();
      @(posedge clk_i); #1;
   endtask

   initial begin
`ifdef CLUSTER_CLOCK_GATING_FPGA_BYPASS_EN
      low();
      rst_ni = 1'b1;
      for (int i = 0; i < 20; i++) begin
         high();
         check("byp_hi0", clk_o0, 1);
         check("byp_hi3", clk_o3, 1);
         check("byp_en0", clk_en_o0, 1);
         low();
         check("byp_lo0", clk_o0, 0);
         check("byp_en3", clk_en_o3, 1);
      end
`else
      // Reset state
      low(); low();
      check("rst_clk_en0", clk_en_o0, 0);
      check("rst_clk_en3", clk_en_o3, 0);
      check("rst_clk_o0", clk_o0, 0);
      check("rst_pulses", pc0 + pc3, 0);
      rst_ni = 1'b1;

      // Idle after release: nothing passes
      b0 = pc0; b3 = pc3;
      repeat (10) low();
      check("idle_pulses0", pc0 - b0, 0);
      check("idle_pulses3", pc3 - b3, 0);
      check("idle_clk_en0", clk_en_o0, 0);

      // Three enabled edges
      b0 = pc0; b3 = pc3;
      en_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         high();
         check($sformatf("en_edge%0d_hi", i), clk_o0, 1);
         low();
      end
      en_i = 1'b0;
      #1;
      check("drop_clk_en0", clk_en_o0, 0);
      check("hold_clk_en3", clk_en_o3, 1);
      repeat (6) low();
      check("en3_pulses0", pc0 - b0, 3);
      check("en3_pulses3", pc3 - b3, 6);

      // Enable toggled inside a high phase is ignored
      repeat (2) low();
      b0 = pc0; b3 = pc3;
      high();
      en_i = 1'b1; #1; en_i = 1'b0; #1;
      check("hi_toggle_clk_o0", clk_o0, 0);
      check("hi_toggle_clk_en0", clk_en_o0, 0);
      low();
      check("hi_toggle_pulses0", pc0 - b0, 0);
      check("hi_toggle_pulses3", pc3 - b3, 0);
      en_i = 1'b1;
      high();
      check("next_edge_clk_o0", clk_o0, 1);
      low();
      en_i = 1'b0;
      check("next_edge_pulses0", pc0 - b0, 1);

      // Test override, then reset mid-pulse
      repeat (5) low();
      b0 = pc0; b3 = pc3;
      test_en_i = 1'b1;
      repeat (8) begin high(); low(); end
      check("test_pulses0", pc0 - b0, 8);
      check("test_pulses3", pc3 - b3, 8);
      high();
      check("test_hi_clk_o0", clk_o0, 1);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_clk_o0", clk_o0, 0);
      check("rst_mid_clk_o3", clk_o3, 0);
      check("rst_mid_clk_en3", clk_en_o3, 0);
      b0 = pc0; b3 = pc3;
      repeat (2) low();
      check("rst_hold_pulses", (pc0 - b0) + (pc3 - b3), 0);
      test_en_i = 1'b0;
      rst_ni = 1'b1;

      // Single enabled cycle: hold window adds three pulses
      b0 = pc0; b3 = pc3;
      en_i = 1'b1;
      high(); low();
      en_i = 1'b0;
      repeat (6) low();
      check("one_cyc_pulses0", pc0 - b0, 1);
      check("one_cyc_pulses3", pc3 - b3, 4);

      // Re-enable after two hold edges reloads the counter without a gap
      b0 = pc0; b3 = pc3;
      en_i = 1'b1;
      high(); check("reload_e1", clk_o3, 1); low();
      en_i = 1'b0;
      high(); check("reload_e2", clk_o3, 1); low();
      high(); check("reload_e3", clk_o3, 1); low();
      en_i = 1'b1;
      high(); check("reload_e4", clk_o3, 1); low();
      en_i = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         high(); check($sformatf("reload_e%0d", i), clk_o3, 1); low();
      end
      high(); check("reload_e8", clk_o3, 0); low();
      check("reload_pulses3", pc3 - b3, 7);
      check("reload_pulses0", pc0 - b0, 2);

      // Random enables against a reference model of en_req
      repeat (5) low();
      m_cnt = 0; exp0 = 0; exp3 = 0;
      b0 = pc0; b3 = pc3;
      for (int i = 0; i < 10000; i++) begin
         en_i      = 1'($urandom_range(0, 1));
         test_en_i = ($urandom_range(0, 7) == 0);
         if (en_i || test_en_i) exp0++;
         if (en_i || test_en_i || m_cnt != 0) exp3++;
         if (en_i) m_cnt = 3;
         else if (m_cnt != 0) m_cnt--;
         low();
      end
      en_i = 1'b0;
      test_en_i = 1'b0;
      check("rand_pulses0", pc0 - b0, exp0);
      check("rand_pulses3", pc3 - b3, exp3);
      repeat (5) low();
      check("short_pulses", short_pulses, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cluster_clock_gating.md
Name: cluster_clock_gating

Overview:
Glitch-free integrated clock-gating (ICG) cell for cluster-level clock gating. Storage elements such as FIFOs use it to stop their register clock when no write is pending. It is a latch-based gate with a scan/test override, an optional idle-hold window, and an observable enable.

Parameters:
IDLE_DELAY, 0, number of extra clk_i rising edges passed to clk_o after en_i deasserts; 0 gives a pure ICG.

Ports:
clk_i  input  1  free-running source clock
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  functional clock enable, sampled in the clk_i low phase
test_en_i  input  1  scan/test override; 1 forces the clock to pass
clk_o  output  1  gated clock
clk_en_o  output  1  current latched enable (status/observability)

Behaviour:
- Gating function:
  - en_req = en_i | test_en_i | hold.
  - en_lat is a level-sensitive latch, transparent while clk_i = 0 and opaque while clk_i = 1.
  - clk_o = clk_i & en_lat.
  - clk_en_o = en_lat.
- Latency: en_req stable before a clk_i rising edge lets that same edge through (zero-cycle). en_req dropping before an edge suppresses that edge.
- Glitch-free:
  - Changes of en_i or test_en_i while clk_i = 1 have no effect until the next low phase.
  - clk_o pulses are always full clk_i high phases; never truncated, never extra.
- Hold counter:
  - cnt has width max(1, clog2(IDLE_DELAY+1)) and is clocked on the clk_i rising edge (ungated).
  - If en_i = 1, cnt <= IDLE_DELAY.
  - Else if cnt != 0, cnt <= cnt - 1.
  - hold = (cnt != 0).
  - With IDLE_DELAY = 0, cnt and hold are constant 0 and the hold logic is optimised away.
- Reset (rst_ni = 0), asynchronous:
  - cnt = 0 and en_lat = 0, so clk_o = 0 and clk_en_o = 0 immediately, including mid-pulse.
  - Reset dominates test_en_i.
  - After rst_ni rises, the first edge that can pass is the first rising edge preceded by a low phase with en_req = 1.
- test_en_i = 1 with rst_ni = 1: clk_o follows clk_i from the next low phase onward, regardless of en_i and cnt. cnt keeps updating normally.
- Simultaneous events:
  - en_i = 1 always reloads the counter, regardless of its current value.
  - A deassert-then-reassert of en_i within one low phase is harmless; only the value at the latch-closing edge matters.

Optional Feature:
Macro CLUSTER_CLOCK_GATING_FPGA_BYPASS_EN.
- Defined: clk_o = clk_i combinationally, with no latch and no gating. en_i and test_en_i are ignored for the clock path. clk_en_o is tied to 1; rst_ni affects only the counter.
- Undefined: full latch-based gating as above.

Decomposition:
- Package cluster_cg_pkg holds one function, cg_cnt_width(delay), returning max(1, clog2(delay+1)). No typedefs are needed.
- Natural sub-module: cg_enable_latch, the resettable transparent-low latch. It is isolated so synthesis can map it to a technology ICG or latch cell.
- cluster_clock_gating contains the hold counter, OR logic, AND gate, and the FPGA bypass.

Test Plan:
1. Reset release, IDLE_DELAY=0, en_i=0, test_en_i=0, 10 cycles -> clk_o stays 0, clk_en_o=0. Then en_i=1 for cycles 3-5 -> exactly 3 clk_o pulses, aligned to edges 3,4,5.
2. en_i toggles 0->1->0 while clk_i=1 -> no pulse and no glitch on clk_o in that high phase. en_i=1 over the next low phase -> the following edge passes as a full-width pulse.
3. test_en_i=1, en_i=0, 8 cycles -> 8 clk_o pulses, identical to clk_i. rst_ni=0 asserted mid-high-phase -> clk_o falls immediately and stays 0 until release.
4. IDLE_DELAY=3: en_i=1 for 1 cycle then 0 -> 4 clk_o pulses total. en_i re-asserted after 2 hold edges -> counter reloads and gating continues without a gap.
5. Random en_i/test_en_i stimulus for 10k cycles -> clk_o pulse count equals the count of edges whose preceding low phase had en_req=1. No pulse is shorter than the clk_i high time.
6. Build with CLUSTER_CLOCK_GATING_FPGA_BYPASS_EN and en_i=0 -> clk_o == clk_i every cycle, clk_en_o=1.
